// File: rtl/writeback_sequencer_pkg.sv
// Shared types for the writeback stage in front of the 8x16 register bank.
// Consumers: writeback_sequencer_if, wb_fifo, writeback_sequencer.
package cisc_min_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic                  WrX;
        logic [REG_ADDR_W-1:0] DestX;
        logic [DATA_W-1:0]     DataX;
        logic                  WrY;
        logic [REG_ADDR_W-1:0] DestY;
        logic [DATA_W-1:0]     DataY;
    } wb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_YIELD  = 2'd2
    } wb_state_t;

    function automatic logic destHit(input logic wr, input logic [REG_ADDR_W-1:0] dest,
                                     input logic [REG_ADDR_W-1:0] selX,
                                     input logic [REG_ADDR_W-1:0] selY);
        return wr && ((dest == selX) || (dest == selY));
    endfunction
endpackage

// File: rtl/writeback_sequencer_if.sv
// Execute-result handshake, operand-fetch request and bank-port bundle.
// slave = writeback_sequencer side, master = execute/decode/bank side.
interface writeback_sequencer_if #(parameter int DEPTH = 2);
    import cisc_min_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  ResValid, ResReady, ResWrX, ResWrY;
    logic [REG_ADDR_W-1:0] ResDestX, ResDestY;
    logic [DATA_W-1:0]     ResDataX, ResDataY;
    logic                  RdReq, RdGrant, RdHazard;
    logic [REG_ADDR_W-1:0] RdSelX, RdSelY;
    logic [REG_ADDR_W-1:0] RxSel, RySel;
    logic [DATA_W-1:0]     WriteData_Rx, WriteData_Ry;
    logic                  WriteRx, WriteRy;
    logic [CW-1:0]         PendingCount;

    modport slave (
        input  ResValid, ResWrX, ResWrY, ResDestX, ResDestY, ResDataX, ResDataY,
               RdReq, RdSelX, RdSelY,
        output ResReady, RdGrant, RdHazard, RxSel, RySel,
               WriteData_Rx, WriteData_Ry, WriteRx, WriteRy, PendingCount
    );
    modport master (
        output ResValid, ResWrX, ResWrY, ResDestX, ResDestY, ResDataX, ResDataY,
               RdReq, RdSelX, RdSelY,
        input  ResReady, RdGrant, RdHazard, RxSel, RySel,
               WriteData_Rx, WriteData_Ry, WriteRx, WriteRy, PendingCount
    );
endinterface

// File: rtl/writeback_sequencer_wb_fifo.sv
// DEPTH-entry result FIFO; exposes per-slot write enables/dests for hazard compare.
module wb_fifo
    import cisc_min_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 ClockInput,
    input  logic                                 ResetInput,
    input  logic                                 push,
    input  wb_entry_t                            pushData,
    input  logic                                 pop,
    output wb_entry_t                            headData,
    output logic [DEPTH-1:0]                     slotWrX,
    output logic [DEPTH-1:0]                     slotWrY,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     slotDestX,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     slotDestY,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH):0]               count
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [DEPTH-1:0]      slotValid;
    logic [PW-1:0]         rdPtr, wrPtr;
    logic                  doPush, doPop;

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Pointers wrap for free since DEPTH is a power of two.
    always_ff @(posedge ClockInput) begin
        if (!ResetInput) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            slotValid <= '0;
        end else begin
            if (doPush) begin
                wrPtr            <= wrPtr + 1'b1;
                slotValid[wrPtr] <= 1'b1;
            end
            if (doPop) begin
                rdPtr            <= rdPtr + 1'b1;
                slotValid[rdPtr] <= 1'b0;
            end
            count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
        end
    end

    always_ff @(posedge ClockInput) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slotWrX[i]   = slotValid[i] && mem[i].WrX;
            slotWrY[i]   = slotValid[i] && mem[i].WrY;
            slotDestX[i] = mem[i].DestX;
            slotDestY[i] = mem[i].DestY;
        end
    end
endmodule

// File: rtl/writeback_sequencer.sv
// Writeback sequencer: queues results, commits one per cycle, owns bank select mux.
// Optional WB_BYPASS_EN: idle+empty results write the bank in the accepting cycle.
module writeback_sequencer
    import cisc_min_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic                  ClockInput,
    input logic                  ResetInput,
    writeback_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_t                        state, stateNext;
    wb_entry_t                        resEntry, head, src;
    logic [DEPTH-1:0]                 slotWrX, slotWrY;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] slotDestX, slotDestY;
    logic                             full, empty, accept, hasWrite, bypass, push, commit;
    logic                             drive, hazard, rdHazard, nonEmptyNext;
    logic [CW-1:0]                    count, countNext;

    // Same-destination dual write: X wins, Y is dropped before it is queued.
    assign resEntry = '{WrX:   bus.ResWrX,
                        DestX: bus.ResDestX,
                        DataX: bus.ResDataX,
                        WrY:   bus.ResWrY && !(bus.ResWrX && (bus.ResDestX == bus.ResDestY)),
                        DestY: bus.ResDestY,
                        DataY: bus.ResDataY};

    assign bus.ResReady = ResetInput && !full;
    assign accept       = bus.ResValid && bus.ResReady;
    assign hasWrite     = resEntry.WrX || resEntry.WrY;
`ifdef WB_BYPASS_EN
    assign bypass = (state == S_IDLE) && empty && accept && hasWrite;
`else
    assign bypass = 1'b0;
`endif
    assign push   = accept && hasWrite && !bypass;
    assign commit = (state == S_COMMIT) && !empty;

    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .ClockInput (ClockInput),
        .ResetInput (ResetInput),
        .push       (push),
        .pushData   (resEntry),
        .pop        (commit),
        .headData   (head),
        .slotWrX    (slotWrX),
        .slotWrY    (slotWrY),
        .slotDestX  (slotDestX),
        .slotDestY  (slotDestY),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    assign countNext    = count + CW'(push) - CW'(commit);
    assign nonEmptyNext = (countNext != '0);

    always_comb begin
        hazard = destHit(accept && resEntry.WrX, resEntry.DestX, bus.RdSelX, bus.RdSelY) ||
                 destHit(accept && resEntry.WrY, resEntry.DestY, bus.RdSelX, bus.RdSelY);
        for (int i = 0; i < DEPTH; i++)
            hazard = hazard || destHit(slotWrX[i], slotDestX[i], bus.RdSelX, bus.RdSelY)
                            || destHit(slotWrY[i], slotDestY[i], bus.RdSelX, bus.RdSelY);
    end

    assign rdHazard     = bus.RdReq && hazard;
    assign bus.RdHazard = rdHazard;
    assign bus.RdGrant  = ResetInput && bus.RdReq && !rdHazard && !bypass &&
                          ((state == S_IDLE) || (state == S_YIELD));

    // A clean read after a commit forces one yield cycle, so reads get every 2nd cycle.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:   if (push) stateNext = S_COMMIT;
            S_COMMIT: begin
                if (bus.RdReq && !rdHazard && nonEmptyNext) stateNext = S_YIELD;
                else if (nonEmptyNext)                       stateNext = S_COMMIT;
                else                                         stateNext = S_IDLE;
            end
            S_YIELD:  stateNext = nonEmptyNext ? S_COMMIT : S_IDLE;
            default:  stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge ClockInput) begin
        if (!ResetInput) state <= S_IDLE;
        else             state <= stateNext;
    end

    assign src   = commit ? head : resEntry;
    assign drive = ResetInput && (commit || bypass);

    assign bus.RxSel        = drive ? src.DestX : bus.RdSelX;
    assign bus.RySel        = drive ? src.DestY : bus.RdSelY;
    assign bus.WriteRx      = drive && src.WrX;
    assign bus.WriteRy      = drive && src.WrY;
    assign bus.WriteData_Rx = (drive && src.WrX) ? src.DataX : '0;
    assign bus.WriteData_Ry = (drive && src.WrY) ? src.DataY : '0;
    assign bus.PendingCount = count;
endmodule
